sevenseg_capture: RTL and testbench

//  Receive side of the seven-segment interface: samples a multiplexed display bus (7 segment lines

---
 rtl/sevenseg_pkg.sv | 42 ++++
 rtl/sevenseg_to_bcd.sv | 28 ++
 rtl/sevenseg_capture.sv | 156 +++++++++++++++
 tb/tb_sevenseg_capture.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared seven-segment tables and types for the encode and capture directions.
// Segment order is {a,b,c,d,e,f,g}, active high.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;

  localparam logic [3:0] BCD_BAD = 4'hF;

  typedef struct packed {
    logic bad_pat;
    logic multi;
    logic ovf;
  } err_t;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sevenseg_to_bcd.sv
// Combinational segment-pattern to BCD lookup; ok_o low for anything outside 0..9.
module sevenseg_to_bcd
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       ok_o,
  output logic [3:0] bcd_o
);

  always_comb begin
    ok_o  = 1'b1;
    bcd_o = BCD_BAD;
    case (seg_i)
      SEG_0:   bcd_o = 4'd0;
      SEG_1:   bcd_o = 4'd1;
      SEG_2:   bcd_o = 4'd2;
      SEG_3:   bcd_o = 4'd3;
      SEG_4:   bcd_o = 4'd4;
      SEG_5:   bcd_o = 4'd5;
      SEG_6:   bcd_o = 4'd6;
      SEG_7:   bcd_o = 4'd7;
      SEG_8:   bcd_o = 4'd8;
      SEG_9:   bcd_o = 4'd9;
      default: ok_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Recovers per-digit BCD values from a multiplexed seven-segment bus and
// reports digit changes through a one-deep valid/ready event register.
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NDIG-1:0]         an_in,
  output logic [4*NDIG-1:0]       digits,
  output logic [NDIG-1:0]         digit_vld,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [$clog2(NDIG)-1:0] ev_idx,
  output logic [3:0]              ev_val,
  input  logic                    clear_err,
  output logic                    err_bad_pat,
  output logic                    err_multi,
  output logic                    err_ovf
);

  localparam int SW = NDIG + 7;
  localparam int IW = $clog2(NDIG);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [SW-1:0]           s1_q, s2_q, prev_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    cap_q, cap_d;
  logic [NDIG-1:0][3:0]    dig_q, dig_d;
  logic [NDIG-1:0]         vld_q, vld_d;
  logic                    ev_valid_q, ev_valid_d;
  logic [IW-1:0]           ev_idx_q, ev_idx_d;
  logic [3:0]              ev_val_q, ev_val_d;
  err_t                    err_q, err_d, err_set;

  logic [NDIG-1:0]         an_s;
  logic [6:0]              seg_s;
  logic                    dec_ok;
  logic [3:0]              dec_bcd;
  logic                    an_any, an_multi;
  logic [IW-1:0]           an_idx;
  logic                    new_ev;
  logic [IW-1:0]           new_idx;
  logic [3:0]              new_val;

  // After a stable window prev_q holds the settled sample, so decode from it.
  assign an_s  = prev_q[SW-1:7];
  assign seg_s = prev_q[6:0];

  sevenseg_to_bcd u_dec (
    .seg_i (seg_s),
    .ok_o  (dec_ok),
    .bcd_o (dec_bcd)
  );

  // Stability counter; the capture pulse fires only on the cycle cnt reaches its ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (s2_q != prev_q)      cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    cap_d = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
  end

  always_comb begin
    an_any   = |an_s;
    an_multi = |(an_s & (an_s - NDIG'(1)));
    an_idx   = '0;
    for (int i = 0; i < NDIG; i++)
      if (an_s[i]) an_idx = IW'(i);
  end

  always_comb begin
    dig_d   = dig_q;
    vld_d   = vld_q;
    err_set = '0;
    new_ev  = 1'b0;
    new_idx = an_idx;
    new_val = dec_bcd;
    if (cap_q && an_any) begin
      if (an_multi) begin
        err_set.multi = 1'b1;
      end else if (dec_ok) begin
        dig_d[an_idx] = dec_bcd;
        vld_d[an_idx] = 1'b1;
        new_ev        = !vld_q[an_idx] || (dig_q[an_idx] != dec_bcd);
      end else begin
        vld_d[an_idx]   = 1'b0;
        err_set.bad_pat = 1'b1;
        new_ev          = vld_q[an_idx];
        new_val         = BCD_BAD;
      end
    end
  end

  // A pop in the same cycle frees the slot, so a new event can replace the popped one.
  always_comb begin
    ev_valid_d = ev_valid_q;
    ev_idx_d   = ev_idx_q;
    ev_val_d   = ev_val_q;
    err_d      = err_q & ~{$bits(err_t){clear_err}};
    if (new_ev) begin
      if (!ev_valid_q || ev_ready) begin
        ev_valid_d = 1'b1;
        ev_idx_d   = new_idx;
        ev_val_d   = new_val;
      end else begin
        err_d.ovf = 1'b1;
      end
    end else if (ev_valid_q && ev_ready) begin
      ev_valid_d = 1'b0;
    end
    err_d = err_d | err_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      cap_q      <= 1'b0;
      dig_q      <= '0;
      vld_q      <= '0;
      ev_valid_q <= 1'b0;
      ev_idx_q   <= '0;
      ev_val_q   <= '0;
      err_q      <= '0;
    end else begin
      s1_q       <= {an_in, seg_in};
      s2_q       <= s1_q;
      prev_q     <= s2_q;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      dig_q      <= dig_d;
      vld_q      <= vld_d;
      ev_valid_q <= ev_valid_d;
      ev_idx_q   <= ev_idx_d;
      ev_val_q   <= ev_val_d;
      err_q      <= err_d;
    end
  end

  assign digits      = dig_q;
  assign digit_vld   = vld_q;
  assign ev_valid    = ev_valid_q;
  assign ev_idx      = ev_idx_q;
  assign ev_val      = ev_val_q;
  assign err_bad_pat = err_q.bad_pat;
  assign err_multi   = err_q.multi;
  assign err_ovf     = err_q.ovf;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Scoreboarded bench: a pin-level reference model predicts captured digits and
// events; a monitor pops and compares every accepted event.
module tb_sevenseg_capture;

  localparam int NDIG = 4;
  localparam int S    = 8;
  localparam int IW   = $clog2(NDIG);

  logic                clk, rst_n;
  logic [6:0]          seg_in;
  logic [NDIG-1:0]     an_in;
  logic [4*NDIG-1:0]   digits;
  logic [NDIG-1:0]     digit_vld;
  logic                ev_valid, ev_ready;
  logic [IW-1:0]       ev_idx;
  logic [3:0]          ev_val;
  logic                clear_err, err_bad_pat, err_multi, err_ovf;

  sevenseg_capture #(.NDIG(NDIG), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
    .digits(digits), .digit_vld(digit_vld), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_idx(ev_idx), .ev_val(ev_val),
    .clear_err(clear_err), .err_bad_pat(err_bad_pat),
    .err_multi(err_multi), .err_ovf(err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  logic [IW+3:0] exp_q[$];

  // reference model state
  int   seg_tbl[10] = '{'h7E, 'h30, 'h6D, 'h79, 'h33, 'h5B, 'h5F, 'h70, 'h7F, 'h7B};
  int   m_val[NDIG];
  bit   m_vld[NDIG];
  bit   m_bad, m_multi, m_ovf;
  logic [NDIG+6:0] cur_pat;
  int   run;
  bit   done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NDIG; i++) begin m_val[i] = 0; m_vld[i] = 0; end
    m_bad = 0; m_multi = 0; m_ovf = 0;
    cur_pat = '0; run = 0; done = 1;
    exp_q.delete();
  endtask

  task automatic model_cap(input logic [NDIG-1:0] an, input logic [6:0] seg);
    int idx, v;
    if ($countones(an) == 0) return;
    if ($countones(an) > 1) begin m_multi = 1; return; end
    idx = 0;
    for (int i = 0; i < NDIG; i++) if (an[i]) idx = i;
    v = -1;
    for (int k = 0; k < 10; k++) if (seg_tbl[k] == int'(seg)) v = k;
    if (v >= 0) begin
      if (!m_vld[idx] || m_val[idx] != v) exp_q.push_back({IW'(idx), 4'(v)});
      m_val[idx] = v; m_vld[idx] = 1;
    end else begin
      m_bad = 1;
      if (m_vld[idx]) exp_q.push_back({IW'(idx), 4'hF});
      m_vld[idx] = 0;
    end
  endtask

  function automatic logic [4*NDIG-1:0] m_digits();
    logic [4*NDIG-1:0] d;
    for (int i = 0; i < NDIG; i++) d[4*i +: 4] = 4'(m_val[i]);
    return d;
  endfunction

  function automatic logic [NDIG-1:0] m_vldv();
    logic [NDIG-1:0] d;
    for (int i = 0; i < NDIG; i++) d[i] = m_vld[i];
    return d;
  endfunction

  // Drive a pin pattern for n cycles; a run of S identical cycles is one capture.
  task automatic apply(input logic [NDIG-1:0] an, input logic [6:0] seg, input int n,
                       input bit chk_lat = 0);
    int lat;
    if ({an, seg} != cur_pat) begin cur_pat = {an, seg}; run = 0; done = 0; end
    run += n;
    if (!done && run >= S) begin done = 1; model_cap(an, seg); end
    an_in = an; seg_in = seg;
    lat = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (chk_lat && lat == 0 && ev_valid) lat = i;
    end
    if (chk_lat) chk("ev_latency", lat, S + 3);
  endtask

  task automatic chk_flags(input string name);
    chk(name, {err_bad_pat, err_multi, err_ovf}, {m_bad, m_multi, m_ovf});
  endtask

  // Scoreboard monitor: every accepted event must match the oldest prediction.
  always @(negedge clk) begin
    if (rst_n && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) chk("ev_unexpected", {ev_idx, ev_val}, 32'hDEAD);
      else chk("ev_content", {ev_idx, ev_val}, exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] v1, v2;
    logic [IW+3:0] held;
    rst_n = 0; an_in = '0; seg_in = '0; ev_ready = 1; clear_err = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_outputs", {digits, digit_vld, ev_valid, ev_idx, ev_val,
                          err_bad_pat, err_multi, err_ovf}, '0);
    rst_n = 1;
    repeat (S + 4) @(negedge clk);

    // single digit, latency and no repeat events
    apply(4'b0001, 7'h7E, 20, 1);
    chk("t1_digits", digits[3:0], 4'h0);
    chk("t1_vld", digit_vld, 4'b0001);
    chk("t1_queue_empty", exp_q.size(), 0);

    // three scan rounds of 1,2,3,4
    for (int r = 0; r < 3; r++)
      for (int d = 0; d < 4; d++) apply(4'(1 << d), 7'(seg_tbl[d + 1]), 16);
    chk("t2_digits", digits, 16'h4321);
    chk("t2_vld", digit_vld, 4'b1111);
    chk("t2_queue_empty", exp_q.size(), 0);

    // short glitch mid-digit, then restore
    apply(4'b1000, 7'h7F, S - 2);
    apply(4'b1000, 7'h33, 16);
    chk("t3_digits", digits, 16'h4321);
    chk("t3_queue_empty", exp_q.size(), 0);

    // multiple enables; clear coinciding with a set keeps the flag
    apply(4'b0101, 7'h7E, 20);
    chk_flags("t4_multi_set");
    apply(4'b1010, 7'h7E, S + 2);
    clear_err = 1;
    apply(4'b1010, 7'h7E, 1);
    clear_err = 0;
    m_bad = 0; m_ovf = 0;
    chk_flags("t4_clear_vs_set");
    clear_err = 1;
    apply(4'b1010, 7'h7E, 1);
    clear_err = 0;
    m_bad = 0; m_multi = 0; m_ovf = 0;
    chk_flags("t4_clear_alone");
    chk("t4_digits", digits, 16'h4321);

    // valid then unrecognized pattern on digit 2
    apply(4'b0100, 7'h7F, 16);
    apply(4'b0100, 7'h01, 16);
    chk("t5_vld", digit_vld, 4'b1011);
    chk("t5_digits", digits, 16'h4821);
    chk_flags("t5_bad_pat");

    // randomized scan traffic
    for (int n = 0; n < 150; n++) begin
      int kind, idx, a, b;
      logic [NDIG-1:0] an;
      logic [6:0] seg;
      kind = $urandom_range(0, 9);
      idx  = $urandom_range(0, NDIG - 1);
      an   = 4'(1 << idx);
      seg  = 7'(seg_tbl[$urandom_range(0, 9)]);
      if (kind == 0) an = '0;
      else if (kind == 1) begin
        a = $urandom_range(0, NDIG - 1);
        b = (a + $urandom_range(1, NDIG - 1)) % NDIG;
        an = 4'((1 << a) | (1 << b));
      end else if (kind == 2) seg = 7'($urandom);
      apply(an, seg, $urandom_range(S - 3, S + 8));
    end
    apply('0, '0, S + 10);
    chk("rnd_queue_empty", exp_q.size(), 0);
    chk("rnd_digits", digits, m_digits());
    chk("rnd_vld", digit_vld, m_vldv());
    chk_flags("rnd_flags");

    // overflow: consumer stalled, second change dropped
    ev_ready = 0;
    v1 = 4'((m_val[1] + 1) % 10);
    v2 = 4'((v1 + 1) % 10);
    apply(4'b0010, 7'(seg_tbl[v1]), 16);
    chk("t6_first_valid", ev_valid, 1'b1);
    held = exp_q[0];
    chk("t6_first_ev", {ev_idx, ev_val}, {IW'(1), v1});
    apply(4'b0010, 7'(seg_tbl[v2]), 16);
    m_ovf = 1;
    chk("t6_held_ev", {ev_idx, ev_val}, held);
    chk_flags("t6_ovf");

    // async reset in the middle of a stability window
    an_in = 4'b0001; seg_in = 7'h5B;
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("t6_async_reset", {digits, digit_vld, ev_valid, ev_idx, ev_val,
                           err_bad_pat, err_multi, err_ovf}, '0);
    ev_ready = 1;
    an_in = '0; seg_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    apply(4'b0001, 7'h5B, 20, 1);
    chk("post_reset_digits", digits, 16'h0005);
    apply('0, '0, S + 6);
    chk("post_reset_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
